div_issue_ctrl: RTL

Sequencer between the EXE stage and the two divider IP cores (`module_div_signed`, `module_div_unsigned`). It accepts one div.w/mod.w/div.wu/mod.wu request at a time and drives the AXI-stream operand handshake on the selected core. It captures the single-cycle result pulse, selects quotient or remainder, and holds the result until EXE consumes it. A pipeline flush cancels the operation, and the block drains the in-flight result.

---
 rtl/div_pkg.sv | 30 +++
 rtl/div_issue_ctrl_axis_src_hold.sv | 26 ++
 rtl/div_issue_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider issue controller: op encodings,
// FSM state enum and the default operand width.
package div_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] DIV_W  = 2'b00;
    localparam logic [1:0] MOD_W  = 2'b01;
    localparam logic [1:0] DIV_WU = 2'b10;
    localparam logic [1:0] MOD_WU = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } div_state_t;

    // op[1] picks the unsigned core
    function automatic logic op_is_unsigned(input logic [1:0] op);
        return op[1];
    endfunction

    // op[0] picks the remainder half of the core result
    function automatic logic op_is_mod(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/div_issue_ctrl_axis_src_hold.sv
// One AXI-stream source channel: tvalid is raised on load and held until
// tready is seen; accepted records that the beat has been taken.
module axis_src_hold (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tready,
    output logic tvalid,
    output logic accepted
);

    // Hold tvalid until the handshake, then remember the acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tvalid   <= 1'b0;
            accepted <= 1'b0;
        end else if (load) begin
            tvalid   <= 1'b1;
            accepted <= 1'b0;
        end else if (tvalid && tready) begin
            tvalid   <= 1'b0;
            accepted <= 1'b1;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Divider issue controller: sequences one div/mod request onto the signed
// or unsigned divider core, captures the result pulse and holds it for EXE.
// Optional feature macro: DIV_ZERO_BYPASS_EN (zero divisor answered locally).
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_W-1:0]     req_src1,
    input  logic [DATA_W-1:0]     req_src2,
    input  logic                  flush,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_W-1:0]     res_data,
    output logic                  busy,
    output logic [DATA_W-1:0]     div_dividend_tdata,
    output logic [DATA_W-1:0]     div_divisor_tdata,
    output logic                  sdiv_dividend_tvalid,
    output logic                  sdiv_divisor_tvalid,
    input  logic                  sdiv_dividend_tready,
    input  logic                  sdiv_divisor_tready,
    input  logic                  sdiv_dout_tvalid,
    input  logic [2*DATA_W-1:0]   sdiv_dout_tdata,
    output logic                  udiv_dividend_tvalid,
    output logic                  udiv_divisor_tvalid,
    input  logic                  udiv_dividend_tready,
    input  logic                  udiv_divisor_tready,
    input  logic                  udiv_dout_tvalid,
    input  logic [2*DATA_W-1:0]   udiv_dout_tdata
);

    div_state_t            state;
    div_state_t            next_state;
    logic [1:0]            cur_op;
    logic                  cancel;
    logic                  accept;
    logic                  zero_bypass;
    logic                  load;
    logic                  sel_u;
    logic                  dvd_tvalid;
    logic                  dvs_tvalid;
    logic                  dvd_accepted;
    logic                  dvs_accepted;
    logic                  dvd_tready;
    logic                  dvs_tready;
    logic                  both_done;
    logic                  dout_valid;
    logic [2*DATA_W-1:0]   dout_data;
    logic [DATA_W-1:0]     bypass_data;

    assign accept = (state == IDLE) && req_valid && !flush;

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_bypass = (req_src2 == {DATA_W{1'b0}});
`else
    assign zero_bypass = 1'b0;
`endif

    // Division by zero answers all-ones for div and the dividend for mod
    assign bypass_data = op_is_mod(req_op) ? req_src1 : {DATA_W{1'b1}};
    assign load        = accept && !zero_bypass;

    assign sel_u      = op_is_unsigned(cur_op);
    assign dvd_tready = sel_u ? udiv_dividend_tready : sdiv_dividend_tready;
    assign dvs_tready = sel_u ? udiv_divisor_tready  : sdiv_divisor_tready;
    assign dout_valid = sel_u ? udiv_dout_tvalid     : sdiv_dout_tvalid;
    assign dout_data  = sel_u ? udiv_dout_tdata      : sdiv_dout_tdata;

    // A channel counts as done if it was accepted earlier or handshakes now
    assign both_done = (dvd_accepted || (dvd_tvalid && dvd_tready)) &&
                       (dvs_accepted || (dvs_tvalid && dvs_tready));

    axis_src_hold u_dividend (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .tready   (dvd_tready),
        .tvalid   (dvd_tvalid),
        .accepted (dvd_accepted)
    );

    axis_src_hold u_divisor (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .tready   (dvs_tready),
        .tvalid   (dvs_tvalid),
        .accepted (dvs_accepted)
    );

    assign sdiv_dividend_tvalid = dvd_tvalid && !sel_u;
    assign sdiv_divisor_tvalid  = dvs_tvalid && !sel_u;
    assign udiv_dividend_tvalid = dvd_tvalid && sel_u;
    assign udiv_divisor_tvalid  = dvs_tvalid && sel_u;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode, including flush/cancel routing into DRAIN
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = zero_bypass ? DONE : ISSUE;
                end else begin
                    next_state = IDLE;
                end
            end
            ISSUE: begin
                if (both_done) begin
                    next_state = (cancel || flush) ? DRAIN : WAIT;
                end else begin
                    next_state = ISSUE;
                end
            end
            WAIT: begin
                if (dout_valid) begin
                    next_state = flush ? IDLE : DONE;
                end else if (flush) begin
                    next_state = DRAIN;
                end else begin
                    next_state = WAIT;
                end
            end
            DONE: begin
                if (flush || res_ready) begin
                    next_state = IDLE;
                end else begin
                    next_state = DONE;
                end
            end
            DRAIN: begin
                if (dout_valid) begin
                    next_state = IDLE;
                end else begin
                    next_state = DRAIN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, cancel flag and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_op             <= 2'b00;
            cancel             <= 1'b0;
            div_dividend_tdata <= {DATA_W{1'b0}};
            div_divisor_tdata  <= {DATA_W{1'b0}};
            res_data           <= {DATA_W{1'b0}};
            res_valid          <= 1'b0;
        end else begin
            if (accept) begin
                cur_op <= req_op;
                cancel <= 1'b0;
            end else if (state == ISSUE && flush) begin
                cancel <= 1'b1;
            end
            if (load) begin
                div_dividend_tdata <= req_src1;
                div_divisor_tdata  <= req_src2;
            end
            if (accept && zero_bypass) begin
                res_data <= bypass_data;
            end else if (state == WAIT && dout_valid && !flush) begin
                res_data <= op_is_mod(cur_op) ? dout_data[DATA_W-1:0]
                                              : dout_data[2*DATA_W-1:DATA_W];
            end
            res_valid <= (next_state == DONE);
        end
    end

endmodule
